// File: rtl/opcode_pipe_hazard_if.sv
// ============================================================================
// Module   : opcode_pipe_hazard_if
// Brief    : Fetch/control-unit signal bundle for the pipeline hazard tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface opcode_pipe_hazard_if #(
    parameter int IW = 16
);
    logic [IW-1:0] InstrIF;
    logic          BranchTaken;
    logic [IW-1:0] InstrID;
    logic [3:0]    OpcodeID;
    logic [3:0]    OpcodeEX;
    logic [3:0]    OpcodeMEM;
    logic [3:0]    OpcodeWB;
    logic [3:0]    FunctionCode;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          FlushIF;
    logic          Stall;
    logic          Halted;

    modport master (
        output InstrIF, BranchTaken,
        input  InstrID, OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB, FunctionCode,
        input  PCWrite, IFIDWrite, FlushIF, Stall, Halted
    );

    modport slave (
        input  InstrIF, BranchTaken,
        output InstrID, OpcodeID, OpcodeEX, OpcodeMEM, OpcodeWB, FunctionCode,
        output PCWrite, IFIDWrite, FlushIF, Stall, Halted
    );
endinterface

`default_nettype wire

// File: rtl/opcode_pipe_hazard.sv
// ============================================================================
// Module   : opcode_pipe_hazard
// Brief    : ID..WB instruction tracking, load-use/branch hazard stall, flush
//            and halt control for a 4-stage-after-fetch pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module opcode_pipe_hazard #(
    parameter int         IW  = 16,
    parameter logic [3:0] NOP = 4'b0000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    opcode_pipe_hazard_if.slave bus
);

    localparam logic [3:0] c_op_atype = 4'b0001;
    localparam logic [3:0] c_op_jump  = 4'b0010;
    localparam logic [3:0] c_op_halt  = 4'b0011;
    localparam logic [3:0] c_op_lbu   = 4'b0100;
    localparam logic [3:0] c_op_lw    = 4'b0110;
    localparam logic [3:0] c_op_and   = 4'b1001;
    localparam logic [3:0] c_op_or    = 4'b1010;
    localparam logic [3:0] c_op_blt   = 4'b1100;
    localparam logic [3:0] c_op_bgt   = 4'b1101;
    localparam logic [3:0] c_op_beq   = 4'b1110;
    localparam logic [IW-1:0] c_bubble = {NOP, {(IW-4){1'b0}}};

    function automatic logic is_writer(input logic [3:0] op);
        return op inside {c_op_atype, c_op_and, c_op_or, c_op_lbu, c_op_lw};
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == c_op_lbu) || (op == c_op_lw);
    endfunction

    logic [IW-1:0] r_id, r_ex, r_mem, r_wb;
    logic          r_halted;

    logic [3:0] w_op_id, w_op_ex, w_op_mem, w_op_wb;
    logic [3:0] w_src1, w_src2;
    logic       w_id_reads, w_id_branch, w_id_jump, w_id_halt;
    logic       w_ex_d1_hit, w_ex_d2_hit, w_mem_ld_hit;
    logic       w_load_use, w_branch_haz, w_stall, w_flush, w_drained;
    logic       w_unused;

    assign w_op_id  = r_id[15:12];
    assign w_op_ex  = r_ex[15:12];
    assign w_op_mem = r_mem[15:12];
    assign w_op_wb  = r_wb[15:12];
    assign w_src1   = r_id[11:8];
    assign w_src2   = r_id[7:4];

    assign w_id_reads  = !(w_op_id inside {NOP, c_op_jump, c_op_halt});
    assign w_id_branch = w_op_id inside {c_op_blt, c_op_bgt, c_op_beq};
    assign w_id_jump   = (w_op_id == c_op_jump);
    assign w_id_halt   = (w_op_id == c_op_halt);

    // EX destination hits: op1 for every writer, op2 only for A-type function 1111
    assign w_ex_d1_hit  = is_writer(w_op_ex) && ((r_ex[11:8] == w_src1) || (r_ex[11:8] == w_src2));
    assign w_ex_d2_hit  = (w_op_ex == c_op_atype) && (r_ex[3:0] == 4'hF)
                          && ((r_ex[7:4] == w_src1) || (r_ex[7:4] == w_src2));
    assign w_mem_ld_hit = is_load(w_op_mem) && ((r_mem[11:8] == w_src1) || (r_mem[11:8] == w_src2));

    assign w_load_use   = w_id_reads && is_load(w_op_ex) && w_ex_d1_hit;
    assign w_branch_haz = w_id_branch && (w_ex_d1_hit || w_ex_d2_hit || w_mem_ld_hit);
    assign w_stall      = w_load_use || w_branch_haz;
    assign w_flush      = !w_stall && (w_id_jump || (w_id_branch && bus.BranchTaken));
    assign w_drained    = (w_op_ex == NOP) && (w_op_mem == NOP) && (w_op_wb == NOP);

    // Only opcode and function of WB reach the control unit
    assign w_unused = ^r_wb[11:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id     <= '0;
            r_ex     <= '0;
            r_mem    <= '0;
            r_wb     <= '0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_stall || w_id_halt) begin
                r_ex  <= c_bubble;
                r_mem <= r_ex;
                r_wb  <= r_mem;
                if (w_id_halt && w_drained) begin
                    r_halted <= 1'b1;
                end
            end else begin
                r_id  <= w_flush ? c_bubble : bus.InstrIF;
                r_ex  <= r_id;
                r_mem <= r_ex;
                r_wb  <= r_mem;
            end
        end
    end

    assign bus.InstrID      = r_id;
    assign bus.OpcodeID     = w_op_id;
    assign bus.OpcodeEX     = w_op_ex;
    assign bus.OpcodeMEM    = w_op_mem;
    assign bus.OpcodeWB     = w_op_wb;
    assign bus.FunctionCode = r_wb[3:0];
    assign bus.Stall        = w_stall;
    assign bus.FlushIF      = w_flush && !r_halted;
    assign bus.PCWrite      = !r_halted && !w_stall && !w_id_halt;
    assign bus.IFIDWrite    = !r_halted && !w_stall && !w_id_halt;
    assign bus.Halted       = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_opcode_pipe_hazard.sv
// ============================================================================
// Module   : tb_opcode_pipe_hazard
// Brief    : Scoreboard bench with a register-set reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_opcode_pipe_hazard;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    opcode_pipe_hazard_if bus ();
    opcode_pipe_hazard dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] instr_id;
        logic [3:0]  op_id, op_ex, op_mem, op_wb, fn;
        logic        pcw, ifidw, flush, stall, halted;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_pipe[4];
    bit          m_halted = 1'b0;
    bit          m_known  = 1'b0;
    int          halted_cycles = 0;

    function automatic bit is_load(input logic [3:0] op);
        return op == 4'h4 || op == 4'h6;
    endfunction

    function automatic bit is_branch(input logic [3:0] op);
        return op == 4'hC || op == 4'hD || op == 4'hE;
    endfunction

    // Does instruction ins write register r?
    function automatic bit writes_reg(input logic [15:0] ins, input int r);
        logic [3:0] op;
        op = ins[15:12];
        if (!(op == 4'h1 || op == 4'h9 || op == 4'hA || op == 4'h4 || op == 4'h6)) return 1'b0;
        if (int'(ins[11:8]) == r) return 1'b1;
        return op == 4'h1 && ins[3:0] == 4'hF && int'(ins[7:4]) == r;
    endfunction

    function automatic bit reads_reg(input logic [15:0] ins, input int r);
        logic [3:0] op;
        op = ins[15:12];
        if (op == 4'h0 || op == 4'h2 || op == 4'h3) return 1'b0;
        return int'(ins[11:8]) == r || int'(ins[7:4]) == r;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, record the expected outputs, then advance the model.
    task automatic cycle(input logic [15:0] ins, input logic bt, input logic r);
        exp_t e;
        bit lu, br, hz, hold;
        logic [15:0] id, ex, mem;
        rst = r;
        bus.InstrIF = ins;
        bus.BranchTaken = bt;
        id = m_pipe[0]; ex = m_pipe[1]; mem = m_pipe[2];
        lu = 0; br = 0;
        for (int k = 0; k < 16; k++) begin
            if (reads_reg(id, k)) begin
                if (is_load(ex[15:12]) && writes_reg(ex, k)) lu = 1;
                if (is_branch(id[15:12]) &&
                    (writes_reg(ex, k) || (is_load(mem[15:12]) && writes_reg(mem, k)))) br = 1;
            end
        end
        hz   = lu || br;
        hold = hz || id[15:12] == 4'h3;
        if (m_known) begin
            e.instr_id = id;
            e.op_id  = id[15:12];
            e.op_ex  = ex[15:12];
            e.op_mem = mem[15:12];
            e.op_wb  = m_pipe[3][15:12];
            e.fn     = m_pipe[3][3:0];
            e.stall  = hz;
            e.flush  = !hz && (id[15:12] == 4'h2 || (is_branch(id[15:12]) && bt));
            e.pcw    = !m_halted && !hold;
            e.ifidw  = e.pcw;
            e.halted = m_halted;
            sb.push_back(e);
        end
        if (r) begin
            for (int k = 0; k < 4; k++) m_pipe[k] = 16'h0;
            m_halted = 0;
            m_known  = 1;
        end else if (m_known && !m_halted) begin
            if (hold) begin
                if (id[15:12] == 4'h3 && ex[15:12] == 0 && mem[15:12] == 0 && m_pipe[3][15:12] == 0)
                    m_halted = 1;
                m_pipe[3] = mem; m_pipe[2] = ex; m_pipe[1] = 16'h0;
            end else begin
                m_pipe[3] = mem; m_pipe[2] = ex; m_pipe[1] = id;
                m_pipe[0] = (id[15:12] == 4'h2 || (is_branch(id[15:12]) && bt)) ? 16'h0 : ins;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] op, a, b, f;
        op = 4'($urandom_range(0, 15));
        if (op == 4'h3 && $urandom_range(0, 5) != 0) op = 4'h6;
        a  = 4'($urandom_range(0, 3));
        b  = 4'($urandom_range(0, 3));
        f  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        return {op, a, b, f};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("InstrID",      bus.InstrID,      e.instr_id);
                chk("OpcodeID",     bus.OpcodeID,     e.op_id);
                chk("OpcodeEX",     bus.OpcodeEX,     e.op_ex);
                chk("OpcodeMEM",    bus.OpcodeMEM,    e.op_mem);
                chk("OpcodeWB",     bus.OpcodeWB,     e.op_wb);
                chk("FunctionCode", bus.FunctionCode, e.fn);
                chk("PCWrite",      bus.PCWrite,      e.pcw);
                chk("IFIDWrite",    bus.IFIDWrite,    e.ifidw);
                chk("FlushIF",      bus.FlushIF,      e.flush);
                chk("Stall",        bus.Stall,        e.stall);
                chk("Halted",       bus.Halted,       e.halted);
            end
        end
    end

    initial begin : driver
        logic rr;
        for (int k = 0; k < 4; k++) m_pipe[k] = 16'h0;
        cycle(16'h1234, 1'b0, 1'b1);
        cycle(16'h1234, 1'b0, 1'b1);
        cycle(16'h1234, 1'b0, 1'b0);
        // load-use
        cycle(16'h6310, 1'b0, 1'b0);
        cycle(16'h1340, 1'b0, 1'b0);
        repeat (4) cycle(16'h0000, 1'b0, 1'b0);
        // branch on an op2 destination, then taken
        cycle(16'h121F, 1'b0, 1'b0);
        cycle(16'hE200, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b0);
        cycle(16'h0000, 1'b1, 1'b0);
        repeat (3) cycle(16'h0000, 1'b0, 1'b0);
        // jump
        cycle(16'h2005, 1'b0, 1'b0);
        repeat (3) cycle(16'h0000, 1'b0, 1'b0);
        // drain behind Halt, then stay halted under arbitrary fetches
        cycle(16'h9110, 1'b0, 1'b0);
        cycle(16'hA220, 1'b0, 1'b0);
        cycle(16'h3000, 1'b0, 1'b0);
        repeat (10) cycle(rand_instr(), 1'($urandom_range(0, 1)), 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        // reset in the middle of a load-use stall
        cycle(16'h6310, 1'b0, 1'b0);
        cycle(16'h1340, 1'b0, 1'b0);
        cycle(16'h0000, 1'b0, 1'b1);
        repeat (3) cycle(16'h0000, 1'b0, 1'b0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
            rr = (halted_cycles > 4) || ($urandom_range(0, 99) == 0);
            cycle(rand_instr(), 1'($urandom_range(0, 1)), rr);
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
